regfile_sb: RTL

//  Parametrised register file for the RV32 core. Two asynchronous read ports, two synchronous

---
 rtl/core_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 65 ++++++
 rtl/regfile_sb.sv | 122 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: default widths, the hard-wired zero register index
// and the register-address type used by the register file.
package core_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

    typedef logic [$clog2(NREG_DEF)-1:0] regaddr_t;

endpackage : core_pkg

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard for multi-cycle loads.
// A load issue sets busy for its destination and a load writeback clears it.
// When both hit the same register, the issue wins because a newer load has
// overtaken the completing one. Register 0 is never busy. The busy count is a
// registered popcount of the next-state vector, so it tracks the busy vector
// with no extra lag.
module rf_scoreboard
    import core_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_issue_ld,
    input  logic [AW-1:0]   i_issue_rd,
    input  logic            i_we1,
    input  logic [AW-1:0]   i_wa1,
    output logic [NREG-1:0] o_busy,
    output logic [AW:0]     o_busy_cnt
);

    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_busy_cnt;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_cnt_nxt;

    // Next busy state per register: set has priority over clear, x0 is pinned to 0.
    always_comb begin
        w_busy_nxt    = r_busy;
        w_busy_nxt[0] = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (i_issue_ld && (i_issue_rd == AW'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end else if (i_we1 && (i_wa1 == AW'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end else begin
                w_busy_nxt[i] = r_busy[i];
            end
        end
    end

    // Population count of the next busy vector.
    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
        end
    end

    // Busy vector and busy count state; reset drops every pending load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_busy_cnt;

endmodule : rf_scoreboard

// File: rtl/regfile_sb.sv
// RV32 register file: two combinational read ports, two synchronous write
// ports (ALU on port 0, load unit on port 1) with port 0 winning on a
// same-address collision, optional write-to-read bypass, and a busy
// scoreboard for outstanding loads.
module regfile_sb
    import core_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREG   = NREG_DEF,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd1,
    input  logic            issue_ld,
    input  logic [AW-1:0]   issue_rd,
    output logic [AW:0]     busy_cnt
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] w_busy;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;
    logic            w_busy1;
    logic            w_busy2;
    logic            w_fwd_en;

    assign w_fwd_en = (BYPASS != 0);

    rf_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_issue_ld (issue_ld),
        .i_issue_rd (issue_rd),
        .i_we1      (we1),
        .i_wa1      (wa1),
        .o_busy     (w_busy),
        .o_busy_cnt (busy_cnt)
    );

    // Register storage: port 1 first, then port 0, so port 0 wins a collision; x0 stays 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (we1 && (wa1 != ZERO_ADDR)) begin
                r_regs[wa1] <= wd1;
            end
            if (we0 && (wa0 != ZERO_ADDR)) begin
                r_regs[wa0] <= wd0;
            end
        end
    end

    // Read port 1: x0 is constant zero; same-cycle write data forwarded when enabled.
    always_comb begin
        w_rdata1 = r_regs[rs1];
        if (rs1 == ZERO_ADDR) begin
            w_rdata1 = '0;
        end else if (w_fwd_en && we0 && (wa0 == rs1)) begin
            w_rdata1 = wd0;
        end else if (w_fwd_en && we1 && (wa1 == rs1)) begin
            w_rdata1 = wd1;
        end else begin
            w_rdata1 = r_regs[rs1];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        w_rdata2 = r_regs[rs2];
        if (rs2 == ZERO_ADDR) begin
            w_rdata2 = '0;
        end else if (w_fwd_en && we0 && (wa0 == rs2)) begin
            w_rdata2 = wd0;
        end else if (w_fwd_en && we1 && (wa1 == rs2)) begin
            w_rdata2 = wd1;
        end else begin
            w_rdata2 = r_regs[rs2];
        end
    end

    // Hazard flags: a load completing this cycle no longer blocks when forwarding is on.
    always_comb begin
        w_busy1 = w_busy[rs1];
        w_busy2 = w_busy[rs2];
        if (w_fwd_en && we1 && (wa1 == rs1)) begin
            w_busy1 = 1'b0;
        end else begin
            w_busy1 = w_busy[rs1];
        end
        if (w_fwd_en && we1 && (wa1 == rs2)) begin
            w_busy2 = 1'b0;
        end else begin
            w_busy2 = w_busy[rs2];
        end
    end

    assign rdata1 = w_rdata1;
    assign rdata2 = w_rdata2;
    assign busy1  = w_busy1;
    assign busy2  = w_busy2;

endmodule : regfile_sb
